pulse_gen_multi: RTL and testbench

Multi-channel, parametrised one-shot pulse generator for the RISC-V core's control path (pipeline start, fetch release, stall-window and debug strobes). Each channel detects a rising edge on its trigger, emits an output pulse of programmable length, then stays spent until re-armed, unless auto-rearm is selected. Hold kills a pulse in flight, and enable freezes a channel. It replaces the single-bit, fixed-width one-shot flop in the front-end with one block instantiated per cluster of control strobes.

---
 rtl/pulse_gen_multi.sv | 115 +++++++++++
 tb/tb_pulse_gen_multi.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_multi.sv
// Multi-channel one-shot pulse generator: each channel fires a programmable-length
// pulse on a trigger rising edge, then stays spent until re-armed (or auto re-arms).
module pulse_gen_multi #(
  parameter int N_CH       = 4,
  parameter int LEN_W      = 8,
  parameter int AUTO_REARM = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_CH-1:0]       i_en,
  input  logic [N_CH-1:0]       i_trig,
  input  logic [N_CH-1:0]       i_hold,
  input  logic [N_CH-1:0]       i_rearm,
  input  logic [N_CH*LEN_W-1:0] i_len,
  output logic [N_CH-1:0]       o_pulse,
  output logic [N_CH-1:0]       o_busy,
  output logic [N_CH-1:0]       o_spent,
  output logic [N_CH-1:0]       o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_SPENT = 2'd2
  } state_t;

  localparam logic AUTO = (AUTO_REARM != 0);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_q, state_d;
      logic [LEN_W-1:0] cnt_q, cnt_d;
      logic [LEN_W-1:0] len_c;
      logic             trig_q, trig_d;
      logic             pend_q, pend_d;
      logic             pulse_q, pulse_d;
      logic             done_q, done_d;
      logic             edge_c;
      logic             rearm_now_c;

      always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        trig_d      = trig_q;
        pend_d      = pend_q;
        pulse_d     = 1'b0;
        done_d      = 1'b0;
        len_c       = i_len[gi*LEN_W +: LEN_W];
        edge_c      = i_trig[gi] & ~trig_q;
        // A rearm arriving in the exiting cycle counts as if it had been latched earlier.
        rearm_now_c = AUTO | pend_q | i_rearm[gi];

        if (i_en[gi]) begin
          trig_d = i_trig[gi];
          unique case (state_q)
            ST_IDLE: begin
              if (edge_c && !i_hold[gi]) begin
                state_d = ST_PULSE;
                cnt_d   = (len_c == '0) ? '0 : len_c - 1'b1;
              end
            end
            ST_PULSE: begin
              if (i_hold[gi] || (cnt_q == '0)) begin
                state_d = rearm_now_c ? ST_IDLE : ST_SPENT;
                pend_d  = 1'b0;
              end else begin
                cnt_d = cnt_q - 1'b1;
                if (i_rearm[gi]) begin
                  pend_d = 1'b1;
                end
              end
            end
            ST_SPENT: begin
              if (i_rearm[gi]) begin
                state_d = ST_IDLE;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase

          // Done is predicted one cycle ahead so it lands on the final pulse cycle.
          pulse_d = (state_d == ST_PULSE);
          done_d  = (state_d == ST_PULSE) && (cnt_d == '0);
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          trig_q  <= 1'b1;
          pend_q  <= 1'b0;
          pulse_q <= 1'b0;
          done_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          trig_q  <= trig_d;
          pend_q  <= pend_d;
          pulse_q <= pulse_d;
          done_q  <= done_d;
        end
      end

      assign o_pulse[gi] = pulse_q;
      assign o_busy[gi]  = (state_q == ST_PULSE);
      assign o_spent[gi] = (state_q == ST_SPENT);
      assign o_done[gi]  = done_q;
    end
  endgenerate

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: one instance without and one with auto-rearm,
// both driven by the same stimulus.
module tb_pulse_gen_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en, trig, hold, rearm;
  logic [31:0] len;
  logic [3:0]  p0, b0, s0, d0;
  logic [3:0]  p1, b1, s1, d1;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hi_cnt;
  logic [3:0]  exp_p, exp_d;

  always #5 clk = ~clk;

  pulse_gen_multi #(.N_CH(4), .LEN_W(8), .AUTO_REARM(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_trig(trig), .i_hold(hold),
    .i_rearm(rearm), .i_len(len),
    .o_pulse(p0), .o_busy(b0), .o_spent(s0), .o_done(d0)
  );

  pulse_gen_multi #(.N_CH(4), .LEN_W(8), .AUTO_REARM(1)) dut_ar (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_trig(trig), .i_hold(hold),
    .i_rearm(rearm), .i_len(len),
    .o_pulse(p1), .o_busy(b1), .o_spent(s1), .o_done(d1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s val=%0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; trig = 4'b0001; en = 4'hF; hold = '0; rearm = '0; len = '0;
    step(); step();
    check("rst_pulse", p0, 0);
    check("rst_busy",  b0, 0);
    check("rst_spent", s0, 0);
    check("rst_done",  d0, 0);
    check("rst_pulse_ar", p1, 0);

    // Trigger held high through reset must not fire.
    rst = 1'b0;
    step(); step();
    check("held_trig_pulse", p0[0], 0);
    check("held_trig_busy",  b0[0], 0);

    // len=3 pulse.
    len[7:0] = 8'd3; trig = 4'b0000;
    step();
    trig = 4'b0001;
    step();
    for (int i = 1; i <= 3; i++) begin
      check("len3_pulse", p0[0], 1);
      check("len3_done",  d0[0], (i == 3));
      step();
    end
    check("len3_end_pulse", p0[0], 0);
    check("len3_end_done",  d0[0], 0);
    check("len3_end_spent", s0[0], 1);
    check("len3_end_busy",  b0[0], 0);

    // Spent channel ignores edges; rearm; len=0 behaves as 1.
    trig = 4'b0000; step();
    trig = 4'b0001; step();
    check("spent_edge_pulse", p0[0], 0);
    check("spent_edge_spent", s0[0], 1);
    trig = 4'b0000; rearm = 4'b0001; step(); rearm = '0;
    check("rearm_spent", s0[0], 0);
    check("rearm_busy",  b0[0], 0);
    len[7:0] = 8'd0; trig = 4'b0001; step();
    check("len0_pulse", p0[0], 1);
    check("len0_done",  d0[0], 1);
    step();
    check("len0_end_pulse", p0[0], 0);
    check("len0_end_spent", s0[0], 1);

    // Hold two cycles into a len=10 pulse.
    trig = 4'b0000; rearm = 4'b0001; step(); rearm = '0;
    len[7:0] = 8'd10; trig = 4'b0001; step();
    check("hold_pre1", p0[0], 1);
    step();
    check("hold_pre2", p0[0], 1);
    check("hold_pre2_done", d0[0], 0);
    hold = 4'b0001; step(); hold = '0;
    check("hold_pulse", p0[0], 0);
    check("hold_done",  d0[0], 0);
    check("hold_spent", s0[0], 1);

    // Hold coincident with an edge in IDLE: edge lost, stays IDLE.
    trig = 4'b0000; rearm = 4'b0001; step(); rearm = '0;
    check("hold_idle_pre_spent", s0[0], 0);
    trig = 4'b0001; hold = 4'b0001; step();
    check("hold_edge_pulse", p0[0], 0);
    check("hold_edge_busy",  b0[0], 0);
    check("hold_edge_spent", s0[0], 0);
    hold = '0; step();
    check("edge_lost_pulse", p0[0], 0);
    check("edge_lost_busy",  b0[0], 0);

    // Enable low for 4 cycles after 2 cycles of a len=6 pulse.
    trig = 4'b0000; step();
    len[7:0] = 8'd6; trig = 4'b0001; hi_cnt = 0;
    step(); hi_cnt += int'(p0[0]);
    check("en_pre1", p0[0], 1);
    step(); hi_cnt += int'(p0[0]);
    check("en_pre2", p0[0], 1);
    en[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); hi_cnt += int'(p0[0]);
      check("en_off_pulse", p0[0], 0);
      check("en_off_busy",  b0[0], 1);
    end
    en[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(); hi_cnt += int'(p0[0]);
      check("en_resume_pulse", p0[0], 1);
      check("en_resume_done",  d0[0], (i == 4));
    end
    step(); hi_cnt += int'(p0[0]);
    check("en_end_pulse", p0[0], 0);
    check("en_end_spent", s0[0], 1);
    check("en_total_high", hi_cnt, 6);

    // Independent ch0/ch3 pulses (len 5/2); ch0 rearmed mid-pulse.
    rst = 1'b1; trig = '0; en = 4'hF; step();
    rst = 1'b0; step();
    len[7:0] = 8'd5; len[31:24] = 8'd2;
    trig = 4'b0001; step();
    check("ovl_t0_pulse_ar", p1 & 4'b1001, 4'b0001);
    check("ovl_t0_done_ar",  d1 & 4'b1001, 4'b0000);
    for (int t = 1; t <= 6; t++) begin
      trig  = 4'b1001;
      rearm = (t == 2) ? 4'b0001 : 4'b0000;
      step();
      rearm = '0;
      exp_p = {(t >= 1 && t < 3), 2'b00, (t < 5)};
      exp_d = {(t == 2), 2'b00, (t == 4)};
      check($sformatf("ovl_t%0d_pulse_ar", t), p1 & 4'b1001, exp_p);
      check($sformatf("ovl_t%0d_done_ar",  t), d1 & 4'b1001, exp_d);
      check($sformatf("ovl_t%0d_pulse",    t), p0 & 4'b1001, exp_p);
    end
    check("ovl_end_spent_ar", s1 & 4'b1001, 4'b0000);
    check("ovl_end_busy_ar",  b1 & 4'b1001, 4'b0000);
    check("ovl_end_spent",    s0 & 4'b1001, 4'b1000);

    // Auto-rearm restart needs a fresh edge.
    step();
    check("ar_no_retrig", p1 & 4'b1001, 4'b0000);
    trig = 4'b0001; step();
    trig = 4'b1001; step();
    check("ar_restart_ar", p1 & 4'b1001, 4'b1000);
    check("ar_restart",    p0 & 4'b1001, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
